// File: rtl/dec_trigger_ctl.sv
// dec_trigger_ctl: decode-stage trigger CSR owner.
// Holds tdata1/tdata2 for NTRIG PC-match triggers and takes CSR writes over a
// valid/ready handshake. A write is applied in a single APPLY cycle, and matching
// is then blanked for SETTLE cycles so the match logic sees a stable config.
// Raw per-slot matches are qualified with execute/m and pair chaining.
// Sticky hit bits are kept per trigger.
module dec_trigger_ctl #(
   parameter int NTRIG  = 4,
   parameter int SETTLE = 2,
   localparam int IDXW  = (NTRIG > 1) ? $clog2(NTRIG) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [IDXW-1:0]       wr_idx,
   input  logic                  wr_sel,
   input  logic [63:0]           wr_data,
   input  logic                  dbg_mode,
   input  logic [NTRIG-1:0]      i0_match_raw,
   input  logic [NTRIG-1:0]      i1_match_raw,
   output logic [NTRIG-1:0]      trig_execute,
   output logic [NTRIG-1:0]      trig_m,
   output logic [NTRIG-1:0]      trig_match,
   output logic [NTRIG-1:0]      trig_select,
   output logic [NTRIG*64-1:0]   trig_tdata2,
   output logic [NTRIG-1:0]      i0_fire,
   output logic [NTRIG-1:0]      i1_fire,
   output logic                  i0_action_dbg,
   output logic                  i1_action_dbg,
   output logic [NTRIG*64-1:0]   tdata1_rd
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_QUIET = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                wr_ready_q, wr_ready_d;
   logic                accept_s, apply_s, drop_s;

   // Write latched at accept; dbg_mode is captured with it so the filter sees a consistent view.
   logic [IDXW-1:0]     idx_q;
   logic                sel_q;
   logic [63:0]         data_q;
   logic                dbg_q;

   // Per-trigger stored tdata1 fields and tdata2.
   logic [NTRIG-1:0]    dmode_q,  dmode_d;
   logic [NTRIG-1:0]    hit_q,    hit_d;
   logic [NTRIG-1:0]    select_q, select_d;
   logic [NTRIG-1:0]    action_q, action_d;
   logic [NTRIG-1:0]    chain_q,  chain_d;
   logic [NTRIG-1:0]    match_q,  match_d;
   logic [NTRIG-1:0]    m_q,      m_d;
   logic [NTRIG-1:0]    exec_q,   exec_d;
   logic [NTRIG*64-1:0] tdata2_q, tdata2_d;

   logic [NTRIG-1:0]    q0_s, q1_s, f0_s, f1_s;

   // Handshake FSM state, settle counter and registered ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= {CW{1'b0}};
         wr_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_ready_q <= wr_ready_d;
      end
   end

   // Next-state logic: IDLE accepts, APPLY commits for one cycle, QUIET counts down the blanking window.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_ready_d = 1'b0;
      accept_s   = 1'b0;
      apply_s    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wr_valid && wr_ready_q) begin
               accept_s   = 1'b1;
               state_d    = S_APPLY;
               wr_ready_d = 1'b0;
            end else begin
               wr_ready_d = 1'b1;
            end
         end
         S_APPLY: begin
            apply_s = 1'b1;
            state_d = S_QUIET;
            cnt_d   = CW'(SETTLE - 1);
         end
         S_QUIET: begin
            if (cnt_q == {CW{1'b0}}) begin
               state_d    = S_IDLE;
               wr_ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = {CW{1'b0}};
         end
      endcase
   end

   // Capture the accepted write so the bus may change while it is applied.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= {IDXW{1'b0}};
         sel_q  <= 1'b0;
         data_q <= 64'd0;
         dbg_q  <= 1'b0;
      end else if (accept_s) begin
         idx_q  <= wr_idx;
         sel_q  <= wr_sel;
         data_q <= wr_data;
         dbg_q  <= dbg_mode;
      end else begin
         idx_q  <= idx_q;
         sel_q  <= sel_q;
         data_q <= data_q;
         dbg_q  <= dbg_q;
      end
   end

   // A debug-owned trigger may only be rewritten from debug mode; otherwise the write is dropped silently.
   assign drop_s = dmode_q[idx_q] & ~dbg_q;

   // Config next state: hits accumulate from fires; an applied tdata1 write overrides the hit bit.
   always_comb begin
      dmode_d  = dmode_q;
      hit_d    = hit_q | i0_fire | i1_fire;
      select_d = select_q;
      action_d = action_q;
      chain_d  = chain_q;
      match_d  = match_q;
      m_d      = m_q;
      exec_d   = exec_q;
      tdata2_d = tdata2_q;
      if (apply_s && !drop_s) begin
         if (!sel_q) begin
            dmode_d[idx_q]  = data_q[59] & dbg_q;
            hit_d[idx_q]    = data_q[20];
            select_d[idx_q] = data_q[19];
            action_d[idx_q] = data_q[12];
            chain_d[idx_q]  = data_q[11] & ~idx_q[0];
            match_d[idx_q]  = data_q[7];
            m_d[idx_q]      = data_q[6];
            exec_d[idx_q]   = data_q[2];
         end else begin
            tdata2_d[{idx_q, 6'd0} +: 64] = data_q;
         end
      end else begin
         dmode_d = dmode_q;
      end
   end

   // Trigger configuration registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         dmode_q  <= {NTRIG{1'b0}};
         hit_q    <= {NTRIG{1'b0}};
         select_q <= {NTRIG{1'b0}};
         action_q <= {NTRIG{1'b0}};
         chain_q  <= {NTRIG{1'b0}};
         match_q  <= {NTRIG{1'b0}};
         m_q      <= {NTRIG{1'b0}};
         exec_q   <= {NTRIG{1'b0}};
         tdata2_q <= {(NTRIG*64){1'b0}};
      end else begin
         dmode_q  <= dmode_d;
         hit_q    <= hit_d;
         select_q <= select_d;
         action_q <= action_d;
         chain_q  <= chain_d;
         match_q  <= match_d;
         m_q      <= m_d;
         exec_q   <= exec_d;
         tdata2_q <= tdata2_d;
      end
   end

   // Match qualification: execute/m gating, then pair chaining within each slot; blanked outside IDLE.
   always_comb begin
      q0_s = i0_match_raw & exec_q & m_q;
      q1_s = i1_match_raw & exec_q & m_q;
      f0_s = q0_s;
      f1_s = q1_s;
      for (int j = 0; j < NTRIG / 2; j++) begin
         if (chain_q[2*j]) begin
            f0_s[2*j]   = q0_s[2*j] & q0_s[2*j+1];
            f0_s[2*j+1] = q0_s[2*j] & q0_s[2*j+1];
            f1_s[2*j]   = q1_s[2*j] & q1_s[2*j+1];
            f1_s[2*j+1] = q1_s[2*j] & q1_s[2*j+1];
         end else begin
            f0_s[2*j]   = q0_s[2*j];
            f0_s[2*j+1] = q0_s[2*j+1];
            f1_s[2*j]   = q1_s[2*j];
            f1_s[2*j+1] = q1_s[2*j+1];
         end
      end
      if (state_q == S_IDLE) begin
         i0_fire = f0_s;
         i1_fire = f1_s;
      end else begin
         i0_fire = {NTRIG{1'b0}};
         i1_fire = {NTRIG{1'b0}};
      end
      i0_action_dbg = |(i0_fire & action_q);
      i1_action_dbg = |(i1_fire & action_q);
   end

   // Readback image: stored fields in their architectural positions, everything else zero.
   always_comb begin
      tdata1_rd = {(NTRIG*64){1'b0}};
      for (int k = 0; k < NTRIG; k++) begin
         tdata1_rd[k*64 + 59] = dmode_q[k];
         tdata1_rd[k*64 + 20] = hit_q[k];
         tdata1_rd[k*64 + 19] = select_q[k];
         tdata1_rd[k*64 + 12] = action_q[k];
         tdata1_rd[k*64 + 11] = chain_q[k];
         tdata1_rd[k*64 + 7]  = match_q[k];
         tdata1_rd[k*64 + 6]  = m_q[k];
         tdata1_rd[k*64 + 2]  = exec_q[k];
      end
   end

   assign wr_ready     = wr_ready_q;
   assign trig_execute = exec_q;
   assign trig_m       = m_q;
   assign trig_match   = match_q;
   assign trig_select  = select_q;
   assign trig_tdata2  = tdata2_q;

endmodule

// File: tb/tb_dec_trigger_ctl.sv
// Directed bench for dec_trigger_ctl: fire expectations go through a scoreboard queue,
// register/readback expectations are constants derived from the trigger CSR layout.
module tb_dec_trigger_ctl;

   localparam int NTRIG  = 4;
   localparam int SETTLE = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               wr_valid = 1'b0;
   logic               wr_ready;
   logic [1:0]         wr_idx = 2'd0;
   logic               wr_sel = 1'b0;
   logic [63:0]        wr_data = 64'd0;
   logic               dbg_mode = 1'b0;
   logic [NTRIG-1:0]   i0_match_raw = 4'd0;
   logic [NTRIG-1:0]   i1_match_raw = 4'd0;
   logic [NTRIG-1:0]   trig_execute, trig_m, trig_match, trig_select;
   logic [NTRIG*64-1:0] trig_tdata2, tdata1_rd;
   logic [NTRIG-1:0]   i0_fire, i1_fire;
   logic               i0_action_dbg, i1_action_dbg;

   dec_trigger_ctl #(.NTRIG(NTRIG), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_sel(wr_sel),
      .wr_data(wr_data), .dbg_mode(dbg_mode),
      .i0_match_raw(i0_match_raw), .i1_match_raw(i1_match_raw),
      .trig_execute(trig_execute), .trig_m(trig_m), .trig_match(trig_match),
      .trig_select(trig_select), .trig_tdata2(trig_tdata2),
      .i0_fire(i0_fire), .i1_fire(i1_fire),
      .i0_action_dbg(i0_action_dbg), .i1_action_dbg(i1_action_dbg),
      .tdata1_rd(tdata1_rd)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Bench-side view of the config that matters for fire prediction.
   logic [NTRIG-1:0] m_exe = '0, m_m = '0, m_chain = '0, m_act = '0, m_dmode = '0;

   logic [63:0] sb_exp[$];
   string       sb_tag[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NTRIG-1:0] mdl_fire(input logic [NTRIG-1:0] raw);
      logic [NTRIG-1:0] q, f;
      q = raw & m_exe & m_m;
      f = q;
      for (int j = 0; j < NTRIG / 2; j++) begin
         if (m_chain[2*j]) begin
            f[2*j]   = q[2*j] & q[2*j+1];
            f[2*j+1] = q[2*j] & q[2*j+1];
         end
      end
      return f;
   endfunction

   task automatic sb_push(input string tag);
      logic [NTRIG-1:0] f0, f1;
      logic [63:0] e;
      f0 = mdl_fire(i0_match_raw);
      f1 = mdl_fire(i1_match_raw);
      e = '0;
      e[2*NTRIG+1:0] = {|(f1 & m_act), |(f0 & m_act), f1, f0};
      sb_exp.push_back(e);
      sb_tag.push_back(tag);
   endtask

   task automatic sb_pop();
      logic [63:0] obs;
      obs = '0;
      obs[2*NTRIG+1:0] = {i1_action_dbg, i0_action_dbg, i1_fire, i0_fire};
      if (sb_exp.size() == 0) begin
         chk("sb_underflow", 64'd1, 64'd0);
      end else begin
         chk(sb_tag.pop_front(), obs, sb_exp.pop_front());
      end
   endtask

   task automatic fire_check(input string tag, input logic [NTRIG-1:0] r0, input logic [NTRIG-1:0] r1);
      i0_match_raw = r0;
      i1_match_raw = r1;
      sb_push(tag);
      #1;
      sb_pop();
   endtask

   // Full write transaction; blank_raw is driven on i0 while the block is not ready.
   task automatic do_write(input logic [1:0] idx, input logic sel, input logic [63:0] data,
                           input logic dbg, input logic [NTRIG-1:0] blank_raw);
      int lows;
      dbg_mode = dbg;
      wr_idx   = idx;
      wr_sel   = sel;
      wr_data  = data;
      wr_valid = 1'b1;
      chk("wr_ready_at_accept", {63'd0, wr_ready}, 64'd1);
      tick();
      wr_valid     = 1'b0;
      i0_match_raw = blank_raw;
      if (!sel && !(m_dmode[idx] && !dbg)) begin
         m_exe[idx]   = data[2];
         m_m[idx]     = data[6];
         m_chain[idx] = data[11] & ~idx[0];
         m_act[idx]   = data[12];
         m_dmode[idx] = data[59] & dbg;
      end
      lows = 0;
      while (wr_ready !== 1'b1 && lows < 10) begin
         lows++;
         #1;
         chk("blank_fire", {56'd0, i1_fire, i0_fire}, 64'd0);
         tick();
      end
      chk("wr_ready_low_cycles", 64'(lows), 64'(1 + SETTLE));
      i0_match_raw = '0;
      i1_match_raw = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held for two cycles.
      tick();
      tick();
      chk("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
      chk("rst_tdata1_rd", tdata1_rd[63:0] | tdata1_rd[127:64] | tdata1_rd[191:128] | tdata1_rd[255:192], 64'd0);
      chk("rst_tdata2", trig_tdata2[63:0] | trig_tdata2[127:64] | trig_tdata2[191:128] | trig_tdata2[255:192], 64'd0);
      chk("rst_fire", {56'd0, i1_fire, i0_fire}, 64'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_wr_ready", {63'd0, wr_ready}, 64'd1);

      // Trigger 1: execute+m, then tdata2; raw match during settle must be blanked.
      do_write(2'd1, 1'b0, 64'h44, 1'b0, 4'b0010);
      chk("t1_execute", {60'd0, trig_execute}, 64'h2);
      chk("t1_m", {60'd0, trig_m}, 64'h2);
      chk("t1_rd", tdata1_rd[127:64], 64'h44);
      do_write(2'd1, 1'b1, 64'h1000, 1'b0, 4'b0010);
      chk("t1_tdata2", trig_tdata2[127:64], 64'h1000);
      fire_check("t1_idle_fire", 4'b0010, 4'b0000);
      tick();
      i0_match_raw = '0;
      chk("t1_hit_set", tdata1_rd[127:64], 64'h10_0044);

      // Chained pair (0,1).
      do_write(2'd0, 1'b0, 64'h844, 1'b0, 4'b0000);
      do_write(2'd1, 1'b0, 64'h44, 1'b0, 4'b0000);
      chk("t0_rd_chain", tdata1_rd[63:0], 64'h844);
      chk("t1_hit_cleared", tdata1_rd[127:64], 64'h44);
      fire_check("chain_half", 4'b0001, 4'b0000);
      fire_check("chain_pair", 4'b0011, 4'b0000);
      fire_check("chain_cross_slot", 4'b0001, 4'b0010);
      i0_match_raw = '0;
      i1_match_raw = '0;

      // Odd trigger cannot chain; action=1 reported per slot.
      do_write(2'd3, 1'b0, 64'h1844, 1'b0, 4'b0000);
      chk("t3_odd_chain", tdata1_rd[255:192], 64'h1044);
      fire_check("t3_action_i1", 4'b0000, 4'b1000);
      fire_check("both_slots", 4'b0011, 4'b1000);
      i0_match_raw = '0;
      i1_match_raw = '0;

      // dmode protection.
      do_write(2'd2, 1'b0, 64'h0800_0000_0000_0044, 1'b1, 4'b0000);
      chk("t2_dmode_set", tdata1_rd[191:128], 64'h0800_0000_0000_0044);
      do_write(2'd2, 1'b0, 64'h0, 1'b0, 4'b0000);
      chk("t2_protected_tdata1", tdata1_rd[191:128], 64'h0800_0000_0000_0044);
      do_write(2'd2, 1'b1, 64'hABC, 1'b0, 4'b0000);
      chk("t2_protected_tdata2", trig_tdata2[191:128], 64'h0);
      do_write(2'd2, 1'b1, 64'hABC, 1'b1, 4'b0000);
      chk("t2_dbg_tdata2", trig_tdata2[191:128], 64'hABC);
      do_write(2'd0, 1'b0, 64'h0800_0000_0000_0844, 1'b0, 4'b0000);
      chk("t0_dmode_forced0", tdata1_rd[63:0], 64'h844);

      // Hit race: pair fires in the accept cycle of a tdata1 write to trigger 1.
      i0_match_raw = 4'b0011;
      do_write(2'd1, 1'b0, 64'h44, 1'b0, 4'b0000);
      chk("race_t1_written_wins", tdata1_rd[127:64], 64'h44);
      chk("race_t0_hit_kept", tdata1_rd[63:0], 64'h10_0844);

      // Reset in the middle of a write.
      wr_idx   = 2'd3;
      wr_sel   = 1'b1;
      wr_data  = 64'h55;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      tick();
      chk("quiet_wr_ready", {63'd0, wr_ready}, 64'd0);
      rst = 1'b1;
      tick();
      chk("midrst_tdata1_rd", tdata1_rd[63:0] | tdata1_rd[127:64] | tdata1_rd[191:128] | tdata1_rd[255:192], 64'd0);
      chk("midrst_tdata2", trig_tdata2[63:0] | trig_tdata2[127:64] | trig_tdata2[191:128] | trig_tdata2[255:192], 64'd0);
      chk("midrst_execute", {60'd0, trig_execute}, 64'd0);
      rst = 1'b0;
      m_exe = '0; m_m = '0; m_chain = '0; m_act = '0; m_dmode = '0;
      tick();
      chk("midrst_wr_ready", {63'd0, wr_ready}, 64'd1);
      chk("midrst_tdata2_t3", trig_tdata2[255:192], 64'd0);
      do_write(2'd0, 1'b0, 64'h44, 1'b0, 4'b0000);
      fire_check("post_rst_unchained", 4'b0001, 4'b0000);
      i0_match_raw = '0;

      chk("sb_drained", 64'(sb_exp.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
